// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use and ID-branch operand hazards, MDU occupancy
// hold FSM for the EX stage, and a saturating stall-cycle performance counter.
module hazard_stall_ctrl #(
    parameter int unsigned MDU_LAT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic [4:0]       ex_writeaddr,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_writeaddr,
    input  logic             mem_memread,
    input  logic             ex_mdu_start,
    output logic             stall,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // First hold cycle happens in IDLE, so BUSY counts down the remaining MDU_LAT-2.
    localparam logic [7:0] CNT_LOAD = (MDU_LAT > 1) ? 8'(MDU_LAT - 2) : 8'd0;

    state_t           state;
    state_t           state_next;
    logic [7:0]       cnt;
    logic [7:0]       cnt_next;
    logic             mdu_hold;
    logic [CNT_W-1:0] stall_cnt;

    logic ex_rs_hit;
    logic ex_rt_hit;
    logic mem_rs_hit;
    logic mem_rt_hit;
    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_haz;

    assign ex_rs_hit  = id_use_rs && (id_rs == ex_writeaddr)  && (ex_writeaddr  != 5'd0);
    assign ex_rt_hit  = id_use_rt && (id_rt == ex_writeaddr)  && (ex_writeaddr  != 5'd0);
    assign mem_rs_hit = id_use_rs && (id_rs == mem_writeaddr) && (mem_writeaddr != 5'd0);
    assign mem_rt_hit = id_use_rt && (id_rt == mem_writeaddr) && (mem_writeaddr != 5'd0);
    assign ex_hit     = ex_rs_hit || ex_rt_hit;
    assign mem_hit    = mem_rs_hit || mem_rt_hit;

    assign load_use = ex_memread && ex_hit;
    assign br_haz   = id_branch && ((ex_regwrite && ex_hit) || (mem_memread && mem_hit));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mdu_hold   = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mdu_start && (MDU_LAT > 1)) begin
                    mdu_hold   = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Release cycle ignores ex_mdu_start even though the op is still in EX.
                if (cnt != 8'd0) begin
                    mdu_hold = 1'b1;
                    cnt_next = cnt - 8'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        mdu_busy     = 1'b0;
        stall_cycles = '0;
        if (!rst) begin
            mdu_busy     = (state == BUSY);
            stall_cycles = stall_cnt;
            if (mdu_hold) begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idex_hold    = 1'b1;
                exmem_bubble = 1'b1;
            end else if (load_use || br_haz) begin
                stall     = 1'b1;
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pc_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: main instance (MDU_LAT=8), a single-cycle
// MDU instance and a narrow-counter instance share the same stimulus.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_writeaddr, mem_writeaddr;
    logic       id_use_rs, id_use_rt, id_branch;
    logic       ex_regwrite, ex_memread, mem_memread, ex_mdu_start;

    logic        stall_a, pc_hold_a, ifid_hold_a, idex_hold_a, exmem_bubble_a, mdu_busy_a;
    logic [15:0] stall_cycles_a;
    logic        stall_b, pc_hold_b, ifid_hold_b, idex_hold_b, exmem_bubble_b, mdu_busy_b;
    logic [15:0] stall_cycles_b;
    logic        stall_c, pc_hold_c, ifid_hold_c, idex_hold_c, exmem_bubble_c, mdu_busy_c;
    logic [3:0]  stall_cycles_c;

    logic [5:0] ctrl_a, ctrl_b, ctrl_c;
    assign ctrl_a = {stall_a, pc_hold_a, ifid_hold_a, idex_hold_a, exmem_bubble_a, mdu_busy_a};
    assign ctrl_b = {stall_b, pc_hold_b, ifid_hold_b, idex_hold_b, exmem_bubble_b, mdu_busy_b};
    assign ctrl_c = {stall_c, pc_hold_c, ifid_hold_c, idex_hold_c, exmem_bubble_c, mdu_busy_c};

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_LAT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .ex_writeaddr(ex_writeaddr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_writeaddr(mem_writeaddr),
        .mem_memread(mem_memread), .ex_mdu_start(ex_mdu_start), .stall(stall_a),
        .pc_hold(pc_hold_a), .ifid_hold(ifid_hold_a), .idex_hold(idex_hold_a),
        .exmem_bubble(exmem_bubble_a), .mdu_busy(mdu_busy_a), .stall_cycles(stall_cycles_a)
    );

    hazard_stall_ctrl #(.MDU_LAT(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .ex_writeaddr(ex_writeaddr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_writeaddr(mem_writeaddr),
        .mem_memread(mem_memread), .ex_mdu_start(ex_mdu_start), .stall(stall_b),
        .pc_hold(pc_hold_b), .ifid_hold(ifid_hold_b), .idex_hold(idex_hold_b),
        .exmem_bubble(exmem_bubble_b), .mdu_busy(mdu_busy_b), .stall_cycles(stall_cycles_b)
    );

    hazard_stall_ctrl #(.MDU_LAT(8), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .ex_writeaddr(ex_writeaddr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_writeaddr(mem_writeaddr),
        .mem_memread(mem_memread), .ex_mdu_start(ex_mdu_start), .stall(stall_c),
        .pc_hold(pc_hold_c), .ifid_hold(ifid_hold_c), .idex_hold(idex_hold_c),
        .exmem_bubble(exmem_bubble_c), .mdu_busy(mdu_busy_c), .stall_cycles(stall_cycles_c)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch = 1'b0;
        ex_writeaddr = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_writeaddr = 5'd0; mem_memread = 1'b0; ex_mdu_start = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // MDU sequence expectation for cycle j of an op (j=0 is entry into EX).
    function automatic logic [5:0] mdu_exp(input int j, input logic lu);
        logic busy;
        busy = (j >= 1);
        if (j < 7)  return {1'b0, 4'b1111, busy};
        if (lu)     return {3'b111, 2'b00, busy};
        return {5'b00000, busy};
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        expect_eq("reset_ctrl", 32'(ctrl_a), 32'h0);
        expect_eq("reset_cnt", 32'(stall_cycles_a), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Load-use on rs
        ex_memread = 1'b1; ex_writeaddr = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        @(negedge clk);
        expect_eq("load_use_rs", 32'(ctrl_a), 32'b111000);
        expect_eq("cnt_before", 32'(stall_cycles_a), 32'd0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        expect_eq("idle_ctrl", 32'(ctrl_a), 32'h0);
        expect_eq("cnt_after_lu", 32'(stall_cycles_a), 32'd1);
        next_cycle();

        // Register 0 never hazards
        ex_memread = 1'b1; ex_writeaddr = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        @(negedge clk);
        expect_eq("reg0", 32'(ctrl_a), 32'h0);
        next_cycle();
        clear_inputs();

        // Matching rt that is not read
        ex_memread = 1'b1; ex_writeaddr = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
        @(negedge clk);
        expect_eq("rt_unused", 32'(ctrl_a), 32'h0);
        next_cycle();

        // Same, now read: load-use on rt
        id_use_rt = 1'b1;
        @(negedge clk);
        expect_eq("load_use_rt", 32'(ctrl_a), 32'b111000);
        next_cycle();

        // ALU producer in EX, non-branch consumer: forwarded, no stall
        ex_memread = 1'b0; ex_regwrite = 1'b1;
        @(negedge clk);
        expect_eq("alu_fwd", 32'(ctrl_a), 32'h0);
        expect_eq("cnt_2", 32'(stall_cycles_a), 32'd2);
        next_cycle();
        clear_inputs();

        // Branch operand hazards: EX writer, then MEM load, then clear
        id_branch = 1'b1; ex_regwrite = 1'b1; ex_writeaddr = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
        @(negedge clk);
        expect_eq("br_ex", 32'(ctrl_a), 32'b111000);
        next_cycle();
        ex_regwrite = 1'b0; mem_memread = 1'b1; mem_writeaddr = 5'd9;
        @(negedge clk);
        expect_eq("br_mem", 32'(ctrl_a), 32'b111000);
        next_cycle();
        mem_memread = 1'b0;
        @(negedge clk);
        expect_eq("br_clear", 32'(ctrl_a), 32'h0);
        expect_eq("cnt_4", 32'(stall_cycles_a), 32'd4);
        next_cycle();

        // load_use and br_haz together: one stall cycle
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writeaddr = 5'd9;
        @(negedge clk);
        expect_eq("lu_and_br", 32'(ctrl_a), 32'b111000);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        expect_eq("cnt_5", 32'(stall_cycles_a), 32'd5);
        next_cycle();

        // Two back-to-back MDU ops; the second also has a load-use throughout
        ex_mdu_start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic lu;
            lu = (k >= 8);
            ex_memread = lu; ex_writeaddr = 5'd5; id_rs = 5'd5; id_use_rs = lu;
            @(negedge clk);
            expect_eq("mdu_ctrl", 32'(ctrl_a), 32'(mdu_exp(k % 8, lu)));
            expect_eq("lat1_ctrl", 32'(ctrl_b), lu ? 32'b111000 : 32'h0);
            if (k == 8) expect_eq("cnt_after_op1", 32'(stall_cycles_a), 32'd12);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        expect_eq("mdu_done", 32'(ctrl_a), 32'h0);
        expect_eq("cnt_after_op2", 32'(stall_cycles_a), 32'd20);
        expect_eq("sat_cnt", 32'(stall_cycles_c), 32'd15);
        expect_eq("lat1_cnt", 32'(stall_cycles_b), 32'd13);
        next_cycle();

        // Reset at T+3 of an MDU sequence
        ex_mdu_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_eq("pre_rst_ctrl", 32'(ctrl_a), 32'(mdu_exp(k, 1'b0)));
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        expect_eq("rst_busy_ctrl", 32'(ctrl_a), 32'h0);
        expect_eq("rst_busy_cnt", 32'(stall_cycles_a), 32'd0);
        next_cycle();
        @(negedge clk);
        expect_eq("rst_hold_ctrl", 32'(ctrl_a), 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expect_eq("post_rst_ctrl", 32'(ctrl_a), 32'(mdu_exp(k, 1'b0)));
            if (k == 0) expect_eq("post_rst_cnt", 32'(stall_cycles_a), 32'd0);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        expect_eq("post_rst_idle", 32'(ctrl_a), 32'h0);
        expect_eq("post_rst_cnt7", 32'(stall_cycles_a), 32'd7);
        expect_eq("post_rst_sat", 32'(stall_cycles_c), 32'd7);
        expect_eq("lat1_never_busy", 32'(ctrl_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard and stall controller for the five-stage pipeline. It drives the `stall` (bubble) input of the ID/EX register and the hold/bubble controls of PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use and ID-stage branch operand hazards combinationally.
- Runs a sequential occupancy FSM that freezes the front of the pipe while a multi-cycle multiply/divide (MDU) op sits in EX.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MDU_LAT, 8: total cycles an MDU op occupies EX; legal range 1..255.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_branch  input  1  ID instruction is a branch resolved in ID.
- ex_writeaddr  input  5  destination register of the EX instruction.
- ex_regwrite  input  1  EX instruction writes the register file.
- ex_memread  input  1  EX instruction is a load.
- mem_writeaddr  input  5  destination register of the MEM instruction.
- mem_memread  input  1  MEM instruction is a load.
- ex_mdu_start  input  1  EX holds an MDU op; stays high while that op is held in EX.
- stall  output  1  insert bubble into ID/EX; drives the ID/EX stall input.
- pc_hold  output  1  PC keeps its value.
- ifid_hold  output  1  IF/ID keeps its value.
- idex_hold  output  1  ID/EX keeps its value (no bubble).
- exmem_bubble  output  1  EX/MEM loads a bubble.
- mdu_busy  output  1  FSM is in BUSY.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_hold=1.

Behaviour:
- Match definitions, with wa a destination address:
  - rs_hit(wa) = id_use_rs & (id_rs==wa) & (wa!=0)
  - rt_hit(wa) = id_use_rt & (id_rt==wa) & (wa!=0)
  - hit(wa) = rs_hit | rt_hit
  - Register 0 never causes a hazard.
- load_use = ex_memread & hit(ex_writeaddr).
- br_haz = id_branch & ((ex_regwrite & hit(ex_writeaddr)) | (mem_memread & hit(mem_writeaddr))).
- FSM states IDLE and BUSY, with an 8-bit down counter cnt.
- IDLE:
  - If ex_mdu_start=1 and MDU_LAT>1: mdu_hold=1 this cycle, cnt<=MDU_LAT-2, next state BUSY.
  - Otherwise stay in IDLE with mdu_hold=0.
- BUSY:
  - If cnt!=0: mdu_hold=1, cnt<=cnt-1.
  - If cnt==0: mdu_hold=0, next state IDLE.
  - ex_mdu_start is ignored in BUSY.
- Net effect: mdu_hold is high for exactly MDU_LAT-1 consecutive cycles, so the op occupies EX for MDU_LAT cycles.
  - The release cycle (BUSY, cnt==0) never retriggers, even though ex_mdu_start is still high.
  - A new MDU op entering EX the following cycle starts a fresh sequence.
- MDU_LAT==1: FSM never leaves IDLE; mdu_hold is always 0.
- Outputs are combinational from inputs plus registered state, valid in the same cycle:
  - mdu_hold=1: pc_hold=ifid_hold=idex_hold=exmem_bubble=1, stall=0. MDU hold takes priority and suppresses bubble insertion.
  - mdu_hold=0 and (load_use|br_haz): stall=pc_hold=ifid_hold=1, idex_hold=exmem_bubble=0.
  - Otherwise: all control outputs 0.
- mdu_busy = (state==BUSY).
- stall_cycles increments by 1 on each posedge where pc_hold=1, and saturates at all-ones.
- Reset:
  - While rst=1, all outputs are forced to 0 combinationally.
  - On the reset edge: state<=IDLE, cnt<=0, stall_cycles<=0.
  - Reset mid-BUSY aborts the sequence. The first cycle after reset is IDLE, so a still-asserted ex_mdu_start starts a new full sequence.
- Simultaneous load_use and br_haz: single stall, counted once.

Test Plan:
- Load-use: ex_memread=1, ex_writeaddr=5, id_rs=5, id_use_rs=1 -> stall=pc_hold=ifid_hold=1 for that cycle; idex_hold=0; stall_cycles 0->1.
- Register 0 and unused operand:
  - ex_memread=1, ex_writeaddr=0, id_rs=0, id_use_rs=1 -> all controls 0.
  - ex_writeaddr=7, id_rt=7, id_use_rt=0 -> all controls 0.
- Branch hazards:
  - id_branch=1, ex_regwrite=1, ex_writeaddr=9, id_rt=9, id_use_rt=1 -> stall=1.
  - Next cycle mem_memread=1, mem_writeaddr=9, ex_regwrite=0 -> stall=1.
  - Following cycle mem_memread=0 -> stall=0.
- MDU, MDU_LAT=8: ex_mdu_start held high 8 cycles from T -> idex_hold=exmem_bubble=pc_hold=1 on T..T+6, 0 on T+7; mdu_busy high T+1..T+7; stall_cycles +7.
  - Same run with load_use asserted throughout -> stall stays 0 on T..T+6 and is 1 on T+7.
- Back-to-back MDU ops: second op enters EX at T+8 -> holds again on T+8..T+14.
  - MDU_LAT=1 -> no holds, mdu_busy never set.
- Reset: rst=1 at T+3 of an MDU sequence -> outputs 0 during rst. After release with ex_mdu_start=1 -> fresh 7-cycle hold. stall_cycles=0 after reset; forced near all-ones it saturates and does not wrap.
